ddr_avmm_arbiter: RTL and testbench

DDR_AVMM_ARBITER -- requirements
Module: ddr_avmm_arbiter

---
 rtl/mu_arb_pkg.sv | 33 +++
 rtl/ddr_outstanding_ctr.sv | 58 +++++
 rtl/ddr_avmm_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ddr_avmm_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mu_arb_pkg.sv
// mu_arb_pkg: shared types and defaults for the DDR Avalon-MM arbiter.
//   arb_state_e      - arbiter FSM states (IDLE, BUSY, DRAIN)
//   DEF_*            - default parameter values for the arbiter
//   pick_grant()     - two-requester grant choice with alternation
package mu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W          = 33;
    localparam int unsigned DEF_DATA_W          = 8;
    localparam int unsigned DEF_MAX_OUTSTANDING = 8;
    localparam int unsigned DEF_BURST_MAX       = 16;

    // When both ask, the one that did not hold the last grant wins;
    // otherwise the sole requester wins.
    function automatic logic pick_grant(input logic req0, input logic req1,
                                        input logic last_grant);
        logic g;
        if (req0 && req1) begin
            g = ~last_grant;
        end else if (req1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/ddr_outstanding_ctr.sv
// ddr_outstanding_ctr: counts DDR reads accepted but not yet returned.
//   clk_i, rst_n_i  - clock, asynchronous active-low reset
//   inc_i           - a read was accepted this cycle
//   valid_i         - raw DDR readdatavalid
//   full_o          - count == MAX_OUTSTANDING
//   empty_o         - count == 0
//   next_zero_o     - count will be 0 after this edge
//   take_o          - valid_i is legitimate (count was non-zero)
//   drop_o          - valid_i arrived with nothing outstanding
module ddr_outstanding_ctr #(
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic valid_i,
    output logic full_o,
    output logic empty_o,
    output logic next_zero_o,
    output logic take_o,
    output logic drop_o
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             inc_s;

    assign empty_o     = (count_q == {CNT_W{1'b0}});
    assign full_o      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign take_o      = valid_i & ~empty_o;
    assign drop_o      = valid_i & empty_o;
    // A full counter cannot take another read; the arbiter already blocks it.
    assign inc_s       = inc_i & ~full_o;
    assign next_zero_o = (count_d == {CNT_W{1'b0}});

    // Next count: simultaneous increment and decrement cancel.
    always_comb begin
        count_d = count_q;
        if (inc_s && !take_o) begin
            count_d = count_q + CNT_W'(1'b1);
        end else if (take_o && !inc_s) begin
            count_d = count_q - CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ddr_avmm_arbiter.sv
// ddr_avmm_arbiter: shares one DDR Avalon-MM host port between the matrix
// unit (r0) and the host loader (r1).
//   clk_i, rst_n_i         - clock, asynchronous active-low reset
//   rN_*_i / rN_*_o        - requester N command in, response out
//   avmm_h_ddr_*_o / _i    - shared DDR command out, response in
//   err_o                  - sticky: readdatavalid with nothing outstanding
// Ownership only changes through IDLE, and IDLE is only entered with no
// reads outstanding, so returning data always belongs to the current owner.
module ddr_avmm_arbiter
    import mu_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = DEF_ADDR_W,
    parameter int unsigned DATA_W          = DEF_DATA_W,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned BURST_MAX       = DEF_BURST_MAX
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] r0_address_i,
    input  logic [DATA_W-1:0] r0_writedata_i,
    input  logic              r0_read_i,
    input  logic              r0_write_i,
    input  logic [ADDR_W-1:0] r1_address_i,
    input  logic [DATA_W-1:0] r1_writedata_i,
    input  logic              r1_read_i,
    input  logic              r1_write_i,
    output logic              r0_waitreq_o,
    output logic [DATA_W-1:0] r0_readdata_o,
    output logic              r0_readdatavalid_o,
    output logic              r1_waitreq_o,
    output logic [DATA_W-1:0] r1_readdata_o,
    output logic              r1_readdatavalid_o,
    output logic [ADDR_W-1:0] avmm_h_ddr_address_o,
    output logic [DATA_W-1:0] avmm_h_ddr_writedata_o,
    output logic              avmm_h_ddr_read_o,
    output logic              avmm_h_ddr_write_o,
    input  logic [DATA_W-1:0] avmm_h_ddr_readdata_i,
    input  logic              avmm_h_ddr_readdatavalid_i,
    input  logic              avmm_h_ddr_waitreq_i,
    output logic              err_o
);
    localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               err_q, err_d;
    logic [BURST_W-1:0] burst_q, burst_d, burst_next_s;

    logic               req0_s, req1_s, other_req_s;
    logic               own_rd_s, own_wr_s, own_req_s, own_waitreq_s;
    logic [ADDR_W-1:0]  own_addr_s;
    logic [DATA_W-1:0]  own_wdata_s;
    logic               busy_s, accept_s, rd_accept_s, burst_done_s;
    logic               full_s, empty_s, next_zero_s, take_s, drop_s;

    assign req0_s      = r0_read_i | r0_write_i;
    assign req1_s      = r1_read_i | r1_write_i;
    assign busy_s      = (state_q == ST_BUSY);
    assign other_req_s = owner_q ? req0_s : req1_s;

    // Select the owner's command fields.
    always_comb begin
        if (owner_q) begin
            own_addr_s  = r1_address_i;
            own_wdata_s = r1_writedata_i;
            own_rd_s    = r1_read_i;
            own_wr_s    = r1_write_i;
        end else begin
            own_addr_s  = r0_address_i;
            own_wdata_s = r0_writedata_i;
            own_rd_s    = r0_read_i;
            own_wr_s    = r0_write_i;
        end
    end

    assign own_req_s     = own_rd_s | own_wr_s;
    assign own_waitreq_s = avmm_h_ddr_waitreq_i | (own_rd_s & full_s);
    assign accept_s      = busy_s & own_req_s & ~own_waitreq_s;
    assign rd_accept_s   = accept_s & own_rd_s;

    // Accepted commands this grant, saturating at BURST_MAX.
    assign burst_next_s = (accept_s && (burst_q != BURST_W'(BURST_MAX)))
                          ? (burst_q + BURST_W'(1'b1)) : burst_q;
    assign burst_done_s = (burst_next_s == BURST_W'(BURST_MAX));

    ddr_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ctr (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .inc_i       (rd_accept_s),
        .valid_i     (avmm_h_ddr_readdatavalid_i),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .next_zero_o (next_zero_s),
        .take_o      (take_s),
        .drop_o      (drop_s)
    );

    // DDR command forwarding and per-requester waitrequest.
    always_comb begin
        avmm_h_ddr_address_o   = {ADDR_W{1'b0}};
        avmm_h_ddr_writedata_o = {DATA_W{1'b0}};
        avmm_h_ddr_read_o      = 1'b0;
        avmm_h_ddr_write_o     = 1'b0;
        r0_waitreq_o           = 1'b1;
        r1_waitreq_o           = 1'b1;
        if (busy_s) begin
            avmm_h_ddr_address_o   = own_addr_s;
            avmm_h_ddr_writedata_o = own_wdata_s;
            avmm_h_ddr_read_o      = own_rd_s & ~full_s;
            avmm_h_ddr_write_o     = own_wr_s;
            if (owner_q) begin
                r1_waitreq_o = own_waitreq_s;
            end else begin
                r0_waitreq_o = own_waitreq_s;
            end
        end else begin
            r0_waitreq_o = 1'b1;
            r1_waitreq_o = 1'b1;
        end
    end

    // Read response routing; unexpected valids never reach a requester.
    assign r0_readdatavalid_o = take_s & ~owner_q;
    assign r1_readdatavalid_o = take_s & owner_q;
    assign r0_readdata_o      = owner_q ? {DATA_W{1'b0}} : avmm_h_ddr_readdata_i;
    assign r1_readdata_o      = owner_q ? avmm_h_ddr_readdata_i : {DATA_W{1'b0}};

    assign err_d = err_q | drop_s;
    assign err_o = err_q;

    // Arbiter next-state, grant and burst bookkeeping.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        burst_d      = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_s || req1_s) begin
                    owner_d      = pick_grant(req0_s, req1_s, last_grant_q);
                    last_grant_d = owner_d;
                    burst_d      = {BURST_W{1'b0}};
                    state_d      = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                burst_d = burst_next_s;
                if (!own_req_s) begin
                    state_d = empty_s ? ST_IDLE : ST_DRAIN;
                end else if (burst_done_s && other_req_s) begin
                    state_d = next_zero_s ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DRAIN: begin
                state_d = next_zero_s ? ST_IDLE : ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, ownership, burst and error registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            burst_q      <= {BURST_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr_avmm_arbiter.sv
// Directed bench for ddr_avmm_arbiter with default parameters.
module tb_ddr_avmm_arbiter;
    import mu_arb_pkg::*;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 8;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [ADDR_W-1:0] r0_address, r1_address;
    logic [DATA_W-1:0] r0_writedata, r1_writedata;
    logic              r0_read, r0_write, r1_read, r1_write;
    logic              r0_waitreq, r1_waitreq;
    logic [DATA_W-1:0] r0_readdata, r1_readdata;
    logic              r0_rdv, r1_rdv;
    logic [ADDR_W-1:0] ddr_address;
    logic [DATA_W-1:0] ddr_writedata;
    logic              ddr_read, ddr_write;
    logic [DATA_W-1:0] ddr_readdata;
    logic              ddr_rdv, ddr_waitreq;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    ddr_avmm_arbiter dut (
        .clk_i                      (clk_i),
        .rst_n_i                    (rst_n_i),
        .r0_address_i               (r0_address),
        .r0_writedata_i             (r0_writedata),
        .r0_read_i                  (r0_read),
        .r0_write_i                 (r0_write),
        .r1_address_i               (r1_address),
        .r1_writedata_i             (r1_writedata),
        .r1_read_i                  (r1_read),
        .r1_write_i                 (r1_write),
        .r0_waitreq_o               (r0_waitreq),
        .r0_readdata_o              (r0_readdata),
        .r0_readdatavalid_o         (r0_rdv),
        .r1_waitreq_o               (r1_waitreq),
        .r1_readdata_o              (r1_readdata),
        .r1_readdatavalid_o         (r1_rdv),
        .avmm_h_ddr_address_o       (ddr_address),
        .avmm_h_ddr_writedata_o     (ddr_writedata),
        .avmm_h_ddr_read_o          (ddr_read),
        .avmm_h_ddr_write_o         (ddr_write),
        .avmm_h_ddr_readdata_i      (ddr_readdata),
        .avmm_h_ddr_readdatavalid_i (ddr_rdv),
        .avmm_h_ddr_waitreq_i       (ddr_waitreq),
        .err_o                      (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_address = '0; r0_writedata = '0; r0_read = 1'b0; r0_write = 1'b0;
        r1_address = '0; r1_writedata = '0; r1_read = 1'b0; r1_write = 1'b0;
        ddr_readdata = '0; ddr_rdv = 1'b0; ddr_waitreq = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n_i = 1'b0;

        // Reset state, with stray traffic on the inputs
        repeat (2) @(negedge clk_i);
        ddr_rdv = 1'b1; ddr_readdata = 8'h5A; r0_read = 1'b1;
        #1;
        check("rst_r0_waitreq", 64'(r0_waitreq), 64'h1);
        check("rst_r1_waitreq", 64'(r1_waitreq), 64'h1);
        check("rst_ddr_read",   64'(ddr_read),   64'h0);
        check("rst_ddr_write",  64'(ddr_write),  64'h0);
        check("rst_r0_rdv",     64'(r0_rdv),     64'h0);
        check("rst_r1_rdv",     64'(r1_rdv),     64'h0);
        check("rst_err",        64'(err),        64'h0);
        check("rst_state",      64'(dut.state_q), 64'(ST_IDLE));
        idle_inputs();
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Single read by r0
        @(negedge clk_i);
        r0_address = 33'h10; r0_read = 1'b1;
        #1;
        check("s1_idle_waitreq", 64'(r0_waitreq), 64'h1);
        check("s1_idle_ddr_read", 64'(ddr_read), 64'h0);
        @(negedge clk_i); #1;
        check("s1_ddr_addr",    64'(ddr_address), 64'h10);
        check("s1_ddr_read",    64'(ddr_read),    64'h1);
        check("s1_r0_waitreq",  64'(r0_waitreq),  64'h0);
        check("s1_r1_waitreq",  64'(r1_waitreq),  64'h1);
        @(negedge clk_i);
        r0_read = 1'b0; ddr_rdv = 1'b1; ddr_readdata = 8'hA5;
        #1;
        check("s1_r0_rdv",      64'(r0_rdv),      64'h1);
        check("s1_r0_rdata",    64'(r0_readdata), 64'hA5);
        check("s1_r1_rdv",      64'(r1_rdv),      64'h0);
        check("s1_r1_rdata",    64'(r1_readdata), 64'h0);
        check("s1_r1_waitreq2", 64'(r1_waitreq),  64'h1);
        @(negedge clk_i);
        ddr_rdv = 1'b0;
        #1;
        check("s1_drain_read",  64'(ddr_read),    64'h0);
        @(negedge clk_i); #1;
        check("s1_state_idle",  64'(dut.state_q), 64'(ST_IDLE));
        check("s1_err",         64'(err),         64'h0);

        // Simultaneous requests after reset: r0 first, then r1
        do_reset();
        @(negedge clk_i);
        r0_write = 1'b1; r0_address = 33'h20; r0_writedata = 8'h11;
        r1_write = 1'b1; r1_address = 33'h30; r1_writedata = 8'h22;
        #1;
        check("s2_idle_r0_wait", 64'(r0_waitreq), 64'h1);
        check("s2_idle_r1_wait", 64'(r1_waitreq), 64'h1);
        @(negedge clk_i); #1;
        check("s2_r0_addr",     64'(ddr_address),   64'h20);
        check("s2_r0_wdata",    64'(ddr_writedata), 64'h11);
        check("s2_r0_write",    64'(ddr_write),     64'h1);
        check("s2_r0_wait",     64'(r0_waitreq),    64'h0);
        check("s2_r1_blocked",  64'(r1_waitreq),    64'h1);
        @(negedge clk_i);
        r0_write = 1'b0;
        @(negedge clk_i); #1;
        check("s2_idle_between", 64'(dut.state_q), 64'(ST_IDLE));
        check("s2_r1_wait_idle", 64'(r1_waitreq),  64'h1);
        @(negedge clk_i); #1;
        check("s2_r1_addr",     64'(ddr_address),   64'h30);
        check("s2_r1_wdata",    64'(ddr_writedata), 64'h22);
        check("s2_r1_wait",     64'(r1_waitreq),    64'h0);
        check("s2_r0_blocked",  64'(r0_waitreq),    64'h1);
        @(negedge clk_i);
        r1_write = 1'b0;
        @(negedge clk_i); #1;
        check("s2_end_idle",    64'(dut.state_q), 64'(ST_IDLE));

        // Nine back-to-back reads, data returns 20 cycles after the first
        @(negedge clk_i);
        r0_read = 1'b1; r0_address = 33'h100;
        #1;
        check("s3_idle_wait", 64'(r0_waitreq), 64'h1);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk_i);
            r0_address = 33'h100 + 33'(b);
            #1;
            check("s3_accept_wait", 64'(r0_waitreq), 64'h0);
            check("s3_accept_read", 64'(ddr_read),   64'h1);
        end
        for (int b = 8; b < 20; b++) begin
            @(negedge clk_i);
            r0_address = 33'h108;
            #1;
            check("s3_full_wait", 64'(r0_waitreq), 64'h1);
            check("s3_full_read", 64'(ddr_read),   64'h0);
        end
        @(negedge clk_i);
        ddr_rdv = 1'b1; ddr_readdata = 8'hC0;
        #1;
        check("s3_first_rdv",     64'(r0_rdv),      64'h1);
        check("s3_first_rdata",   64'(r0_readdata), 64'hC0);
        check("s3_still_full",    64'(r0_waitreq),  64'h1);
        @(negedge clk_i);
        ddr_rdv = 1'b0;
        #1;
        check("s3_ninth_wait",    64'(r0_waitreq),  64'h0);
        check("s3_ninth_read",    64'(ddr_read),    64'h1);
        check("s3_ninth_addr",    64'(ddr_address), 64'h108);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_i);
            r0_read = 1'b0; ddr_rdv = 1'b1; ddr_readdata = 8'hC1 + 8'(j);
            #1;
            check("s3_ret_rdv",   64'(r0_rdv),      64'h1);
            check("s3_ret_rdata", 64'(r0_readdata), 64'hC1 + 64'(j));
        end
        @(negedge clk_i);
        ddr_rdv = 1'b0;
        #1;
        check("s3_end_idle",  64'(dut.state_q), 64'(ST_IDLE));
        check("s3_err",       64'(err),         64'h0);

        // Burst limit: r0 streams writes while r1 waits
        @(negedge clk_i);
        r0_write = 1'b1; r0_address = 33'h200; r0_writedata = 8'h00;
        for (int w = 0; w < 16; w++) begin
            @(negedge clk_i);
            r1_write = 1'b1; r1_address = 33'h300; r1_writedata = 8'h77;
            r0_address = 33'h200 + 33'(w); r0_writedata = 8'(w);
            #1;
            check("s4_w_wait",    64'(r0_waitreq), 64'h0);
            check("s4_w_write",   64'(ddr_write),  64'h1);
            check("s4_r1_wait",   64'(r1_waitreq), 64'h1);
        end
        @(negedge clk_i);
        r0_address = 33'h210; r0_writedata = 8'h10;
        #1;
        check("s4_17th_stall",   64'(r0_waitreq), 64'h1);
        check("s4_17th_nowrite", 64'(ddr_write),  64'h0);
        check("s4_state_idle",   64'(dut.state_q), 64'(ST_IDLE));
        @(negedge clk_i); #1;
        check("s4_r1_addr",   64'(ddr_address),   64'h300);
        check("s4_r1_wdata",  64'(ddr_writedata), 64'h77);
        check("s4_r1_wait",   64'(r1_waitreq),    64'h0);
        check("s4_r0_wait",   64'(r0_waitreq),    64'h1);
        @(negedge clk_i);
        r1_write = 1'b0;
        @(negedge clk_i); #1;
        check("s4_idle_again", 64'(dut.state_q), 64'(ST_IDLE));
        @(negedge clk_i); #1;
        check("s4_r0_resume",  64'(r0_waitreq),  64'h0);
        check("s4_r0_addr",    64'(ddr_address), 64'h210);
        @(negedge clk_i);
        r0_write = 1'b0;
        @(negedge clk_i); #1;
        check("s4_end_idle",   64'(dut.state_q), 64'(ST_IDLE));

        // r0 releases with three reads outstanding while r1 requests
        @(negedge clk_i);
        r0_read = 1'b1; r0_address = 33'h400;
        @(negedge clk_i);
        r1_write = 1'b1; r1_address = 33'h500; r1_writedata = 8'h99;
        #1;
        check("s5_rd0_wait", 64'(r0_waitreq), 64'h0);
        @(negedge clk_i); #1;
        check("s5_rd1_wait", 64'(r0_waitreq), 64'h0);
        @(negedge clk_i); #1;
        check("s5_rd2_wait", 64'(r0_waitreq), 64'h0);
        @(negedge clk_i);
        r0_read = 1'b0;
        #1;
        check("s5_release_r1_wait", 64'(r1_waitreq), 64'h1);
        for (int v = 0; v < 3; v++) begin
            @(negedge clk_i);
            ddr_rdv = 1'b0;
            #1;
            check("s5_drain_r1_wait", 64'(r1_waitreq),  64'h1);
            check("s5_drain_state",   64'(dut.state_q), 64'(ST_DRAIN));
            @(negedge clk_i);
            ddr_rdv = 1'b1; ddr_readdata = 8'h31 + 8'(v);
            #1;
            check("s5_r0_rdv",      64'(r0_rdv),      64'h1);
            check("s5_r0_rdata",    64'(r0_readdata), 64'h31 + 64'(v));
            check("s5_r1_rdv",      64'(r1_rdv),      64'h0);
            check("s5_r1_wait_rdv", 64'(r1_waitreq),  64'h1);
        end
        @(negedge clk_i);
        ddr_rdv = 1'b0;
        #1;
        check("s5_idle",      64'(dut.state_q), 64'(ST_IDLE));
        check("s5_idle_wait", 64'(r1_waitreq),  64'h1);
        @(negedge clk_i);
        ddr_waitreq = 1'b1;
        #1;
        check("s5_r1_addr",      64'(ddr_address), 64'h500);
        check("s5_r1_ddr_stall", 64'(r1_waitreq),  64'h1);
        @(negedge clk_i);
        ddr_waitreq = 1'b0;
        #1;
        check("s5_r1_go",        64'(r1_waitreq),  64'h0);
        @(negedge clk_i);
        r1_write = 1'b0;
        @(negedge clk_i); #1;
        check("s5_end_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // Unexpected readdatavalid in IDLE is dropped and flagged until reset
        @(negedge clk_i);
        ddr_rdv = 1'b1; ddr_readdata = 8'hEE;
        #1;
        check("s6_r0_rdv_drop", 64'(r0_rdv), 64'h0);
        check("s6_r1_rdv_drop", 64'(r1_rdv), 64'h0);
        check("s6_err_before",  64'(err),    64'h0);
        @(negedge clk_i);
        ddr_rdv = 1'b0;
        #1;
        check("s6_err_set",     64'(err),    64'h1);
        repeat (5) @(negedge clk_i);
        #1;
        check("s6_err_sticky",  64'(err),    64'h1);
        rst_n_i = 1'b0;
        #1;
        check("s6_err_cleared", 64'(err),    64'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i); #1;
        check("s6_err_after",   64'(err),    64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
